// File: rtl/bp_pkg.sv
// Shared definitions for the branch history table: default counter width, counter
// encodings and PC-to-index extraction.
package bp_pkg;

  localparam int unsigned CNT_W_DEFAULT = 2;

  typedef enum logic [1:0] {
    STRONG_NT = 2'd0,
    WEAK_NT   = 2'd1,
    WEAK_T    = 2'd2,
    STRONG_T  = 2'd3
  } cnt_state_e;

  // Instructions are word aligned, so PC[1:0] carry no index information.
  function automatic logic [31:0] pc_to_idx(input logic [31:0] pc, input int unsigned idx_w);
    return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up/down counter that saturates at zero and at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned      Width = 2,
  parameter logic [Width-1:0] Init  = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             up_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      if (up_i) begin
        if (cnt_q != {Width{1'b1}}) cnt_d = cnt_q + Width'(1);
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - Width'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= Init;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor_bht.sv
// Branch history table: PC-indexed saturating counters predicted at ID, trained at EX,
// with saturating resolve/mispredict statistics.
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int unsigned      IDX_W    = 4,
  parameter int unsigned      CNT_W    = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] INIT_CNT = CNT_W'(WEAK_NT),
  parameter int unsigned      STAT_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lookup_valid_i,
  input  logic [31:0]       lookup_pc_i,
  output logic              predict_taken_o,
  input  logic              resolve_valid_i,
  input  logic [31:0]       resolve_pc_i,
  input  logic              resolve_taken_i,
  input  logic              resolve_pred_i,
  output logic              mispredict_o,
  output logic [STAT_W-1:0] branch_cnt_o,
  output logic [STAT_W-1:0] mispred_cnt_o
);

  localparam int unsigned Entries = 2 ** IDX_W;

  logic [IDX_W-1:0] lidx, ridx;
  logic [CNT_W-1:0] cnt [Entries];

  assign lidx = IDX_W'(pc_to_idx(lookup_pc_i, IDX_W));
  assign ridx = IDX_W'(pc_to_idx(resolve_pc_i, IDX_W));

  // Gating with resolve_valid_i first keeps X on resolve_* from reaching any enable.
  for (genvar i = 0; i < Entries; i++) begin : g_entry
    sat_counter #(
      .Width (CNT_W),
      .Init  (INIT_CNT)
    ) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (resolve_valid_i && (ridx == IDX_W'(i))),
      .up_i  (resolve_taken_i),
      .cnt_o (cnt[i])
    );
  end

  // Reads the registered value, so a same-cycle update is seen only from the next cycle.
  assign predict_taken_o = lookup_valid_i & cnt[lidx][CNT_W-1];
  assign mispredict_o    = resolve_valid_i & (resolve_taken_i ^ resolve_pred_i);

  sat_counter #(
    .Width (STAT_W),
    .Init  ('0)
  ) u_branch_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (resolve_valid_i),
    .up_i  (1'b1),
    .cnt_o (branch_cnt_o)
  );

  sat_counter #(
    .Width (STAT_W),
    .Init  ('0)
  ) u_mispred_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (mispredict_o),
    .up_i  (1'b1),
    .cnt_o (mispred_cnt_o)
  );

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Bench for branch_predictor_bht: directed scenarios plus random traffic, checked every
// cycle against a table-of-integers model.
module tb_branch_predictor_bht;

  localparam int Entries = 16;
  localparam int SmallMax = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        resolve_taken;
  logic        resolve_pred;

  logic        pred_w, mis_w, pred_s, mis_s;
  logic [31:0] br_w, mp_w;
  logic [2:0]  br_s, mp_s;

  int     model_tbl [Entries];
  longint m_br, m_mp;
  int     checks = 0;
  int     errors = 0;
  bit     cmp_en = 1'b0;

  always #5 clk = ~clk;

  branch_predictor_bht dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .lookup_valid_i  (lookup_valid),
    .lookup_pc_i     (lookup_pc),
    .predict_taken_o (pred_w),
    .resolve_valid_i (resolve_valid),
    .resolve_pc_i    (resolve_pc),
    .resolve_taken_i (resolve_taken),
    .resolve_pred_i  (resolve_pred),
    .mispredict_o    (mis_w),
    .branch_cnt_o    (br_w),
    .mispred_cnt_o   (mp_w)
  );

  branch_predictor_bht #(.STAT_W(3)) dut_s (
    .clk_i           (clk),
    .rst_i           (rst),
    .lookup_valid_i  (lookup_valid),
    .lookup_pc_i     (lookup_pc),
    .predict_taken_o (pred_s),
    .resolve_valid_i (resolve_valid),
    .resolve_pc_i    (resolve_pc),
    .resolve_taken_i (resolve_taken),
    .resolve_pred_i  (resolve_pred),
    .mispredict_o    (mis_s),
    .branch_cnt_o    (br_s),
    .mispred_cnt_o   (mp_s)
  );

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % Entries);
  endfunction

  function automatic logic [31:0] small_of(input longint v);
    return (v > SmallMax) ? 32'(SmallMax) : 32'(v);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain integer counters clamped to [0,3].
  always @(posedge clk or posedge rst) begin
    int k;
    if (rst) begin
      for (int i = 0; i < Entries; i++) model_tbl[i] <= 1;
      m_br <= 0;
      m_mp <= 0;
    end else if (resolve_valid === 1'b1) begin
      k = idx_of(resolve_pc);
      if (resolve_taken) model_tbl[k] <= (model_tbl[k] >= 3) ? 3 : model_tbl[k] + 1;
      else               model_tbl[k] <= (model_tbl[k] <= 0) ? 0 : model_tbl[k] - 1;
      m_br <= m_br + 1;
      if (resolve_taken != resolve_pred) m_mp <= m_mp + 1;
    end
  end

  always @(negedge clk) begin
    logic exp_pred, exp_mis;
    if (cmp_en) begin
      exp_pred = lookup_valid && (model_tbl[idx_of(lookup_pc)] >= 2);
      exp_mis  = resolve_valid && (resolve_taken != resolve_pred);
      check("predict", 32'(pred_w), 32'(exp_pred));
      check("predict_s", 32'(pred_s), 32'(exp_pred));
      check("mispredict", 32'(mis_w), 32'(exp_mis));
      check("mispredict_s", 32'(mis_s), 32'(exp_mis));
      check("branch_cnt", br_w, 32'(m_br));
      check("mispred_cnt", mp_w, 32'(m_mp));
      check("branch_cnt_s", 32'(br_s), small_of(m_br));
      check("mispred_cnt_s", 32'(mp_s), small_of(m_mp));
    end
  end

  task automatic setin(input logic lv, input logic [31:0] lpc, input logic rv,
                       input logic [31:0] rpc, input logic rt, input logic rp);
    lookup_valid  = lv;
    lookup_pc     = lpc;
    resolve_valid = rv;
    resolve_pc    = rpc;
    resolve_taken = rt;
    resolve_pred  = rp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    setin(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmp_en = 1'b1;

    // Reset state: weakly not-taken, stats clear.
    setin(1, 32'h40, 0, 0, 0, 0);
    #1 check("t1_pred", 32'(pred_w), 0);
    check("t1_br", br_w, 0);
    check("t1_mp", mp_w, 0);
    tick();

    // Two taken resolves with pred=0.
    setin(0, 0, 1, 32'h40, 1, 0);
    #1 check("t2_mis0", 32'(mis_w), 1);
    tick();
    #1 check("t2_mis1", 32'(mis_w), 1);
    tick();
    setin(1, 32'h40, 0, 0, 0, 0);
    #1 check("t2_pred", 32'(pred_w), 1);
    check("t2_mp", mp_w, 2);
    check("t2_br", br_w, 2);

    // Saturation high then low at 0x44.
    for (int i = 0; i < 5; i++) begin
      setin(0, 0, 1, 32'h44, 1, 1);
      tick();
    end
    setin(1, 32'h44, 1, 32'h44, 0, 1);
    #1 check("t3_pred_sat", 32'(pred_w), 1);
    tick();
    setin(1, 32'h44, 1, 32'h44, 0, 1);
    #1 check("t3_pred_after1", 32'(pred_w), 1);
    tick();
    setin(1, 32'h44, 1, 32'h44, 0, 0);
    #1 check("t3_pred_after2", 32'(pred_w), 0);
    tick();
    setin(1, 32'h44, 1, 32'h44, 0, 0);
    tick();
    setin(1, 32'h44, 0, 0, 0, 0);
    #1 check("t3_pred_low", 32'(pred_w), 0);
    tick();

    // Same-cycle lookup and update: no bypass.
    setin(1, 32'h48, 1, 32'h48, 1, 0);
    #1 check("t4_pred_same", 32'(pred_w), 0);
    tick();
    setin(1, 32'h48, 0, 0, 0, 0);
    #1 check("t4_pred_next", 32'(pred_w), 1);
    tick();

    // Aliasing: 0x80 shares index 0 with 0x40.
    setin(1, 32'h80, 0, 0, 0, 0);
    #1 check("t5_alias", 32'(pred_w), 1);
    setin(1, 32'h44, 0, 0, 0, 0);
    #1 check("t5_other", 32'(pred_w), 0);
    check("t6_br_w", br_w, 12);
    check("t6_br_s", 32'(br_s), 7);
    check("t6_mp_w", mp_w, 5);
    check("t6_mp_s", 32'(mp_s), 5);
    tick();

    // Random traffic over a small PC range to force aliasing and saturation.
    for (int i = 0; i < 400; i++) begin
      lookup_valid = 1'($urandom_range(0, 1));
      lookup_pc    = $urandom & 32'h0000_00ff;
      if ($urandom_range(0, 3) != 0) begin
        resolve_valid = 1'b1;
        resolve_pc    = $urandom & 32'h0000_00ff;
        resolve_taken = 1'($urandom_range(0, 1));
        resolve_pred  = 1'($urandom_range(0, 1));
      end else begin
        resolve_valid = 1'b0;
        resolve_pc    = 'x;
        resolve_taken = 1'bx;
        resolve_pred  = 1'bx;
      end
      tick();
    end

    // Asynchronous reset mid-stream with an update pending.
    setin(1, 32'h48, 1, 32'h48, 1, 0);
    #2 rst = 1'b1;
    #1 check("t6_rst_pred", 32'(pred_w), 0);
    check("t6_rst_mis", 32'(mis_w), 1);
    check("t6_rst_br", br_w, 0);
    check("t6_rst_mp", mp_w, 0);
    check("t6_rst_br_s", 32'(br_s), 0);
    tick();
    rst = 1'b0;
    #1 check("t6_discard_pred", 32'(pred_w), 0);
    check("t6_discard_br", br_w, 0);
    setin(0, 0, 0, 0, 0, 0);
    repeat (3) tick();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
